// File: rtl/ahb_sram_ctrl.sv
// ---------------------------------------------------------------------------------------------
// ahb_sram_ctrl
//
// AHB-Lite slave bridging to a 2^AWIDTH x 32-bit SRAM built from four byte-wide banks with
// combinational read data. Supports byte, halfword and word transfers. Misaligned or
// oversized transfers get the two-cycle ERROR response and never touch the SRAM.
//
// Build option:
//   AHB_SRAM_RDATA_REG_EN  defined   -> read data registered, one wait state per read (RWAIT)
//                          undefined -> read data passed through combinationally, no waits
//
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   hsel_i .. hready_i  AHB-Lite slave-side request signals
//   hreadyout_o         slave ready (low during RWAIT and the first ERROR cycle)
//   hresp_o             0 = OKAY, 1 = ERROR
//   hrdata_o            read data, holds its value outside read data phases
//   sram_cen_o          per-lane chip enable, active-low
//   sram_wen_o          per-lane write enable, active-low
//   sram_addr_o         word address (haddr[AWIDTH+1:2]), holds when idle
//   sram_wdata_o        write data, lane n on bits [8n+7:8n]
//   sram_rdata_i        combinational read data from the banks
// ---------------------------------------------------------------------------------------------
module ahb_sram_ctrl #(
  parameter int unsigned AWIDTH = 13
) (
  input  logic              clk,
  input  logic              rst,
  // AHB-Lite slave side
  input  logic              hsel_i,
  input  logic [31:0]       haddr_i,
  input  logic [1:0]        htrans_i,
  input  logic              hwrite_i,
  input  logic [2:0]        hsize_i,
  input  logic [31:0]       hwdata_i,
  input  logic              hready_i,
  output logic              hreadyout_o,
  output logic              hresp_o,
  output logic [31:0]       hrdata_o,
  // SRAM side
  output logic [3:0]        sram_cen_o,
  output logic [3:0]        sram_wen_o,
  output logic [AWIDTH-1:0] sram_addr_o,
  output logic [31:0]       sram_wdata_o,
  input  logic [31:0]       sram_rdata_i
);

`ifdef AHB_SRAM_RDATA_REG_EN
  localparam bit RdataReg = 1'b1;
`else
  localparam bit RdataReg = 1'b0;
`endif

  typedef enum logic [2:0] {
    StIdle,
    StAccess,
    StRwait,
    StErr1,
    StErr2
  } state_e;

  state_e state_q, state_d;

  // Data-phase registers, loaded when an address phase is accepted.
  logic [AWIDTH+1:0] addr_q, addr_d;
  logic              hwrite_q, hwrite_d;
  logic [2:0]        hsize_q, hsize_d;

  logic [31:0]       hrdata_q;
  logic              start;
  logic              illegal;
  logic [3:0]        lane_mask;

  // Address bits above the SRAM range and htrans[0] (SEQ vs NONSEQ) carry no meaning here.
  logic unused_inputs;
  assign unused_inputs = ^{haddr_i[31:AWIDTH+2], htrans_i[0]};

  // ------------------------------------------------------------------------------------------
  // Address-phase decode
  // ------------------------------------------------------------------------------------------
  // hreadyout_o depends only on state_q, so it is safe to use here without a loop.
  assign start = hsel_i & htrans_i[1] & hready_i & hreadyout_o;

  assign illegal = (hsize_i > 3'd2)
                 | ((hsize_i == 3'd1) & haddr_i[0])
                 | ((hsize_i == 3'd2) & (haddr_i[1:0] != 2'b00));

  always_comb begin
    addr_d   = addr_q;
    hwrite_d = hwrite_q;
    hsize_d  = hsize_q;
    if (start) begin
      addr_d   = haddr_i[AWIDTH+1:0];
      hwrite_d = hwrite_i;
      hsize_d  = hsize_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q   <= '0;
      hwrite_q <= 1'b0;
      hsize_q  <= 3'd0;
    end else begin
      addr_q   <= addr_d;
      hwrite_q <= hwrite_d;
      hsize_q  <= hsize_d;
    end
  end

  // ------------------------------------------------------------------------------------------
  // FSM: state register
  // ------------------------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // ------------------------------------------------------------------------------------------
  // FSM: next state
  // ------------------------------------------------------------------------------------------
  // StErr2 drives hreadyout high, so a pipelined address phase is taken there as well.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StAccess, StErr2: begin
        if (start) begin
          if (illegal) begin
            state_d = StErr1;
          end else if (!hwrite_i && RdataReg) begin
            state_d = StRwait;
          end else begin
            state_d = StAccess;
          end
        end else begin
          state_d = StIdle;
        end
      end
      StRwait: state_d = StAccess;
      StErr1:  state_d = StErr2;
      default: state_d = StIdle;
    endcase
  end

  // ------------------------------------------------------------------------------------------
  // Byte-lane mask from the registered size and low address bits
  // ------------------------------------------------------------------------------------------
  always_comb begin
    lane_mask = 4'h0;
    case (hsize_q)
      3'd0:    lane_mask = 4'b0001 << addr_q[1:0];
      3'd1:    lane_mask = addr_q[1] ? 4'b1100 : 4'b0011;
      3'd2:    lane_mask = 4'b1111;
      default: lane_mask = 4'h0;
    endcase
  end

  // ------------------------------------------------------------------------------------------
  // FSM: outputs
  // ------------------------------------------------------------------------------------------
  always_comb begin
    hreadyout_o = 1'b1;
    hresp_o     = 1'b0;
    sram_cen_o  = 4'hF;
    sram_wen_o  = 4'hF;
    unique case (state_q)
      StAccess: begin
        if (hwrite_q) begin
          sram_cen_o = ~lane_mask;
          sram_wen_o = ~lane_mask;
        end else if (!RdataReg) begin
          // With registered read data the SRAM was already read in StRwait.
          sram_cen_o = 4'h0;
        end
      end
      StRwait: begin
        hreadyout_o = 1'b0;
        sram_cen_o  = 4'h0;
      end
      StErr1: begin
        hreadyout_o = 1'b0;
        hresp_o     = 1'b1;
      end
      StErr2: begin
        hresp_o = 1'b1;
      end
      default: ;
    endcase
    // A reset arriving during a write data phase must not let the write commit at that edge.
    if (rst) begin
      sram_cen_o = 4'hF;
      sram_wen_o = 4'hF;
    end
  end

  assign sram_addr_o  = addr_q[AWIDTH+1:2];
  assign sram_wdata_o = hwdata_i;

  // ------------------------------------------------------------------------------------------
  // Read data path
  // ------------------------------------------------------------------------------------------
`ifdef AHB_SRAM_RDATA_REG_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      hrdata_q <= 32'h0;
    end else if (state_q == StRwait) begin
      hrdata_q <= sram_rdata_i;
    end
  end

  assign hrdata_o = hrdata_q;
`else
  logic rd_phase;
  assign rd_phase = (state_q == StAccess) && !hwrite_q;

  // Capture the last read word so hrdata_o holds it once the data phase ends.
  always_ff @(posedge clk) begin
    if (rst) begin
      hrdata_q <= 32'h0;
    end else if (rd_phase) begin
      hrdata_q <= sram_rdata_i;
    end
  end

  assign hrdata_o = rd_phase ? sram_rdata_i : hrdata_q;
`endif

endmodule
